// File: rtl/data_bus_responder.sv
// Data-memory responder for the single-cycle core: a word RAM, plus a peripheral
// window holding a general-purpose output register and a compare-match timer.
// Read data is combinational so the core sees it in the same cycle.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS   = 64,
  parameter logic [31:0] PERIPH_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dataWe,
  input  logic [31:0] dataAddr,
  input  logic [31:0] dataWData,
  output logic [31:0] dataRData,
  output logic [31:0] gpo,
  output logic        timerIrq
);

  localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  typedef enum logic [1:0] {
    REG_GPO  = 2'd0,
    REG_CNT  = 2'd1,
    REG_CMP  = 2'd2,
    REG_CTRL = 2'd3
  } reg_sel_e;

  logic [31:0]   mem [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          periph_hit;
  logic [29:0]   periph_off;
  reg_sel_e      reg_sel;

  logic [31:0] cnt;
  logic [31:0] cmp;
  logic        en;
  logic        irq_en;
  logic        match_flag;

  logic gpo_wr;
  logic cnt_wr;
  logic cmp_wr;
  logic ctrl_wr;
  logic match;

  // Word-granular decode; RAM takes priority should the windows ever overlap.
  // Comparing the full byte address against a multiple of 4 is the same as
  // comparing word addresses, so bits [1:0] have no effect on the decode.
  assign ram_hit    = dataAddr < RAM_BYTES;
  assign ram_idx    = dataAddr[AW+1:2];
  assign periph_off = dataAddr[31:2] - PERIPH_BASE[31:2];
  assign periph_hit = !ram_hit && (periph_off < 30'd4);
  assign reg_sel    = reg_sel_e'(periph_off[1:0]);

  assign gpo_wr  = dataWe && periph_hit && (reg_sel == REG_GPO);
  assign cnt_wr  = dataWe && periph_hit && (reg_sel == REG_CNT);
  assign cmp_wr  = dataWe && periph_hit && (reg_sel == REG_CMP);
  assign ctrl_wr = dataWe && periph_hit && (reg_sel == REG_CTRL);

  // A software load of CNT pre-empts the match reload, and with it the flag set.
  assign match = en && (cnt == cmp) && !cnt_wr;

  assign timerIrq = match_flag & irq_en;

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (dataWe && ram_hit) begin
      mem[ram_idx] <= dataWData;
    end
  end

  // Peripheral registers and timer; all comparisons use pre-edge state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpo        <= '0;
      cnt        <= '0;
      cmp        <= '1;
      en         <= 1'b0;
      irq_en     <= 1'b0;
      match_flag <= 1'b0;
    end else begin
      if (gpo_wr) begin
        gpo <= dataWData;
      end

      if (cnt_wr) begin
        cnt <= dataWData;
      end else if (match) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + 32'd1;
      end

      if (cmp_wr) begin
        cmp <= dataWData;
      end

      // A match in the same cycle as a clearing write leaves the flag set.
      if (match) begin
        match_flag <= 1'b1;
      end else if (ctrl_wr && dataWData[1]) begin
        match_flag <= 1'b0;
      end

      if (ctrl_wr) begin
        en     <= dataWData[0];
        irq_en <= dataWData[2];
      end
    end
  end

  // Combinational read mux from current state; unmapped addresses read zero.
  always_comb begin
    dataRData = '0;
    if (ram_hit) begin
      dataRData = mem[ram_idx];
    end else if (periph_hit) begin
      unique case (reg_sel)
        REG_GPO:  dataRData = gpo;
        REG_CNT:  dataRData = cnt;
        REG_CMP:  dataRData = cmp;
        REG_CTRL: dataRData = {29'd0, irq_en, match_flag, en};
        default:  dataRData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: a behavioural model predicts read data, gpo and
// timerIrq for each access; predictions are queued when the access is driven
// and popped when the DUT outputs are sampled.
module tb_data_bus_responder;

  localparam logic [31:0] PB = 32'h1000_0000;

  logic        clk;
  logic        reset;
  logic        dataWe;
  logic [31:0] dataAddr;
  logic [31:0] dataWData;
  logic [31:0] dataRData;
  logic [31:0] gpo;
  logic        timerIrq;

  data_bus_responder #(
    .RAM_WORDS  (64),
    .PERIPH_BASE(PB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dataWe   (dataWe),
    .dataAddr (dataAddr),
    .dataWData(dataWData),
    .dataRData(dataRData),
    .gpo      (gpo),
    .timerIrq (timerIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] gpo;
    logic        irq;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } stim_t;

  exp_t  sb [$];
  stim_t st [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model state
  logic [31:0] ram_m [64];
  logic [31:0] m_gpo;
  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  logic        m_en;
  logic        m_irqen;
  logic        m_flag;

  function automatic void model_reset();
    m_gpo   = 32'h0;
    m_cnt   = 32'h0;
    m_cmp   = 32'hFFFF_FFFF;
    m_en    = 1'b0;
    m_irqen = 1'b0;
    m_flag  = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'h100) return ram_m[a[7:2]];
    if (a[31:4] == PB[31:4]) begin
      case (a[3:2])
        2'd0:    return m_gpo;
        2'd1:    return m_cnt;
        2'd2:    return m_cmp;
        default: return {29'd0, m_irqen, m_flag, m_en};
      endcase
    end
    return 32'h0;
  endfunction

  // Apply one rising edge to the model using pre-edge values throughout.
  function automatic void model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic        p;
    logic [1:0]  sel;
    logic        cw;
    logic        hit;
    logic [31:0] ncnt;
    logic        nflag;
    p   = we && (a[31:4] == PB[31:4]);
    sel = a[3:2];
    cw  = p && (sel == 2'd1);
    hit = m_en && (m_cnt == m_cmp) && !cw;
    if (cw)        ncnt = wd;
    else if (hit)  ncnt = 32'h0;
    else if (m_en) ncnt = m_cnt + 32'd1;
    else           ncnt = m_cnt;
    nflag = m_flag;
    if (hit) nflag = 1'b1;
    else if (p && sel == 2'd3 && wd[1]) nflag = 1'b0;
    if (we && a < 32'h100) ram_m[a[7:2]] = wd;
    if (p && sel == 2'd0) m_gpo = wd;
    if (p && sel == 2'd2) m_cmp = wd;
    if (p && sel == 2'd3) begin
      m_en    = wd[0];
      m_irqen = wd[2];
    end
    m_cnt  = ncnt;
    m_flag = nflag;
  endfunction

  function automatic void add(input logic we, input logic [31:0] a, input logic [31:0] d);
    stim_t s;
    s.we = we; s.a = a; s.d = d;
    st.push_back(s);
  endfunction

  // One bus cycle: drive at the falling edge, queue the prediction, sample
  // outputs 1 time unit later, then let the rising edge commit.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] r, output logic [31:0] g, output logic q);
    exp_t e;
    @(negedge clk);
    dataWe = we; dataAddr = a; dataWData = wd;
    e.rdata = model_read(a); e.gpo = m_gpo; e.irq = m_flag & m_irqen;
    sb.push_back(e);
    #1;
    r = dataRData; g = gpo; q = timerIrq;
    @(posedge clk);
    model_edge(we, a, wd);
    #1 dataWe = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [4];
    exp_t e;
    addrs[0] = PB; addrs[1] = PB + 32'd4; addrs[2] = PB + 32'd8; addrs[3] = PB + 32'd12;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dataAddr = addrs[i];
      e.rdata = model_read(addrs[i]); e.gpo = m_gpo; e.irq = m_flag & m_irqen;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (dataRData !== e.rdata) begin n_bad++; $display("FAIL reset[%0d] rdata got %h want %h", i, dataRData, e.rdata); end
      n_cmp++;
      if (gpo !== e.gpo) begin n_bad++; $display("FAIL reset[%0d] gpo got %h want %h", i, gpo, e.gpo); end
      n_cmp++;
      if (timerIrq !== e.irq) begin n_bad++; $display("FAIL reset[%0d] irq got %b want %b", i, timerIrq, e.irq); end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] r, g;
    logic        q;
    exp_t        e;
    st.delete();
    add(1, 32'h04, 32'hDEAD_BEEF); add(0, 32'h04, 0);
    add(1, 32'h08, 32'h1111_1111); add(1, 32'h08, 32'h2222_2222); add(0, 32'h08, 0);
    add(1, 32'h05, 32'hCAFE_0001); add(0, 32'h04, 0);
    add(1, 32'h00, 32'h0000_AAAA); add(1, 32'hFC, 32'h0BAD_F00D); add(0, 32'hFC, 0);
    add(1, 32'h100, 32'h5555_5555); add(0, 32'h100, 0); add(0, 32'h00, 0); add(0, 32'hFC, 0);
    foreach (st[i]) begin
      access(st[i].we, st[i].a, st[i].d, r, g, q);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e.rdata) begin n_bad++; $display("FAIL ram[%0d] rdata got %h want %h", i, r, e.rdata); end
      n_cmp++;
      if (g !== e.gpo) begin n_bad++; $display("FAIL ram[%0d] gpo got %h want %h", i, g, e.gpo); end
    end
  endtask

  task automatic test_unmapped_gpo();
    logic [31:0] r, g;
    logic        q;
    exp_t        e;
    st.delete();
    add(1, 32'h2000_0000, 32'h1234_5678); add(0, 32'h2000_0000, 0); add(0, PB, 0);
    add(1, PB, 32'hA5); add(0, PB, 0);
    add(1, PB + 32'h10, 32'hFFFF_FFFF); add(0, PB + 32'h10, 0); add(0, PB + 32'hC, 0);
    add(1, PB + 32'hC, 32'hFFFF_FFF8); add(0, PB + 32'hC, 0); add(0, PB + 32'h2, 0);
    add(0, 32'h04, 0);
    foreach (st[i]) begin
      access(st[i].we, st[i].a, st[i].d, r, g, q);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e.rdata) begin n_bad++; $display("FAIL periph[%0d] rdata got %h want %h", i, r, e.rdata); end
      n_cmp++;
      if (g !== e.gpo) begin n_bad++; $display("FAIL periph[%0d] gpo got %h want %h", i, g, e.gpo); end
      n_cmp++;
      if (q !== e.irq) begin n_bad++; $display("FAIL periph[%0d] irq got %b want %b", i, q, e.irq); end
    end
  endtask

  task automatic test_timer_match();
    logic [31:0] r, g;
    logic        q;
    exp_t        e;
    st.delete();
    add(1, PB + 32'h8, 32'd3); add(1, PB + 32'h4, 32'd0); add(1, PB + 32'hC, 32'h5);
    for (int k = 0; k < 12; k++) add(0, PB + 32'h4, 0);
    add(1, PB + 32'hC, 32'h7);
    for (int k = 0; k < 6; k++) add(0, PB + 32'h4, 0);
    add(0, PB + 32'hC, 0);
    foreach (st[i]) begin
      access(st[i].we, st[i].a, st[i].d, r, g, q);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e.rdata) begin n_bad++; $display("FAIL timer[%0d] rdata got %h want %h", i, r, e.rdata); end
      n_cmp++;
      if (q !== e.irq) begin n_bad++; $display("FAIL timer[%0d] irq got %b want %b", i, q, e.irq); end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] r, g;
    logic        q;
    exp_t        e;
    st.delete();
    // clear flag with a match in the same cycle
    add(1, PB + 32'hC, 32'h2); add(1, PB + 32'h8, 32'd2); add(1, PB + 32'h4, 32'd0);
    add(1, PB + 32'hC, 32'h5); add(0, PB + 32'h4, 0); add(0, PB + 32'h4, 0);
    add(1, PB + 32'hC, 32'h7); add(0, PB + 32'hC, 0);
    // CNT load over increment, then CMP write seen only from the next cycle
    add(1, PB + 32'h4, 32'h10); add(0, PB + 32'h4, 0);
    add(1, PB + 32'h8, 32'h11); add(1, PB + 32'h8, 32'h13);
    add(0, PB + 32'h4, 0); add(0, PB + 32'h4, 0); add(0, PB + 32'h4, 0);
    // wrap at all-ones without a match
    add(1, PB + 32'hC, 32'h2); add(1, PB + 32'h8, 32'hFFFF_FFFE); add(1, PB + 32'h4, 32'hFFFF_FFFF);
    add(1, PB + 32'hC, 32'h1); add(0, PB + 32'h4, 0); add(0, PB + 32'h4, 0);
    add(0, PB + 32'h4, 0); add(0, PB + 32'hC, 0);
    foreach (st[i]) begin
      access(st[i].we, st[i].a, st[i].d, r, g, q);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e.rdata) begin n_bad++; $display("FAIL simul[%0d] rdata got %h want %h", i, r, e.rdata); end
      n_cmp++;
      if (q !== e.irq) begin n_bad++; $display("FAIL simul[%0d] irq got %b want %b", i, q, e.irq); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] r, g;
    logic        q;
    exp_t        e;
    st.delete();
    add(1, PB, 32'hFF); add(1, PB + 32'hC, 32'h2); add(1, PB + 32'h8, 32'd2);
    add(1, PB + 32'h4, 32'd0); add(1, PB + 32'hC, 32'h5);
    for (int k = 0; k < 5; k++) add(0, PB + 32'h4, 0);
    foreach (st[i]) begin
      access(st[i].we, st[i].a, st[i].d, r, g, q);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e.rdata) begin n_bad++; $display("FAIL arst_pre[%0d] rdata got %h want %h", i, r, e.rdata); end
    end
    // Mid-cycle reset pulse, entirely between two rising edges
    @(negedge clk);
    dataWe = 1'b0; dataAddr = PB + 32'h4;
    e.rdata = model_read(dataAddr); e.gpo = m_gpo; e.irq = m_flag & m_irqen;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (dataRData !== e.rdata) begin n_bad++; $display("FAIL arst_cnt_before rdata got %h want %h", dataRData, e.rdata); end
    n_cmp++;
    if (timerIrq !== e.irq) begin n_bad++; $display("FAIL arst_irq_before got %b want %b", timerIrq, e.irq); end
    reset = 1'b1;
    model_reset();
    dataAddr = PB + 32'hC;
    e.rdata = model_read(dataAddr); e.gpo = m_gpo; e.irq = 1'b0;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (dataRData !== e.rdata) begin n_bad++; $display("FAIL arst_ctrl rdata got %h want %h", dataRData, e.rdata); end
    n_cmp++;
    if (gpo !== e.gpo) begin n_bad++; $display("FAIL arst_gpo got %h want %h", gpo, e.gpo); end
    n_cmp++;
    if (timerIrq !== e.irq) begin n_bad++; $display("FAIL arst_irq got %b want %b", timerIrq, e.irq); end
    #1 reset = 1'b0;
    st.delete();
    add(0, 32'h04, 0); add(0, PB + 32'h4, 0); add(0, PB + 32'h4, 0); add(0, PB + 32'h8, 0); add(0, PB, 0);
    foreach (st[i]) begin
      access(st[i].we, st[i].a, st[i].d, r, g, q);
      e = sb.pop_front();
      n_cmp++;
      if (r !== e.rdata) begin n_bad++; $display("FAIL arst_post[%0d] rdata got %h want %h", i, r, e.rdata); end
      n_cmp++;
      if (g !== e.gpo) begin n_bad++; $display("FAIL arst_post[%0d] gpo got %h want %h", i, g, e.gpo); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    dataWe    = 1'b0;
    dataAddr  = 32'h0;
    dataWData = 32'h0;
    test_reset();
    test_ram();
    test_unmapped_gpo();
    test_timer_match();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
